spi_regfile_peripheral: RTL and testbench

//   Parametrised SPI (mode 0) register-file peripheral with integrated input synchronisers and readback.

---
 rtl/spi_regfile_peripheral_if.sv | 11 +
 rtl/spi_regfile_peripheral.sv | 156 +++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pad bundle between an SPI controller (master) and the register-file peripheral (slave).
interface spi_regfile_peripheral_if;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;
    logic miso_oe;

    modport master (output sclk, mosi, cs_n, input miso, miso_oe);
    modport slave  (input sclk, mosi, cs_n, output miso, miso_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register file: synchronises the pads into m_clk, decodes R/W + address + data frames,
// commits writes on cs_n release and shifts register contents out on MISO for reads.
module spi_regfile_peripheral #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         m_clk,
    input  logic                         rst,
    spi_regfile_peripheral_if.slave      spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, OVER} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES:0]   vld_pipe_q, vld_pipe_d;
    logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_W-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0]      rd_q, rd_d;
    logic                   miso_q, miso_d, miso_oe_q, miso_oe_d, wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

    logic sclk_s, mosi_s, cs_s, armed;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [ADDR_W-1:0] fr_addr;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    // Edges are only trusted once the synchronisers and delayed copies hold real pad values,
    // so a cs_n held low across reset release does not look like a fresh frame start.
    assign armed     = vld_pipe_q[SYNC_STAGES];
    assign sclk_rise = armed & sclk_s & ~sclk_prev_q;
    assign sclk_fall = armed & ~sclk_s & sclk_prev_q;
    assign cs_rise   = armed & cs_s & ~cs_prev_q;
    assign cs_fall   = armed & ~cs_s & cs_prev_q;
    assign fr_addr   = shreg_q[DATA_W +: ADDR_W];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
        vld_pipe_d  = {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rd_d        = rd_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;

        if (cs_rise) begin
            // A same-cycle sclk edge is dropped: the frame is judged on the count so far.
            if (state_q != IDLE && shreg_q[FRAME_W-1] && cnt_q == CNT_FRAME) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (fr_addr == ADDR_W'(k)) begin
                        regs_d[k]   = shreg_q[DATA_W-1:0];
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = fr_addr;
                    end
                end
            end
            state_d   = IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else if (cs_fall) begin
            state_d   = CMD;
            cnt_d     = '0;
            shreg_d   = '0;
            miso_oe_d = 1'b1;
        end else if (sclk_rise && state_q != IDLE) begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            if (state_q != OVER) shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
            case (state_q)
                CMD: begin
                    if (cnt_d == CNT_CMD) begin
                        if (shreg_d[ADDR_W]) begin
                            state_d = WDATA;
                        end else begin
                            state_d = RDATA;
                            rd_d    = '0;
                            for (int k = 0; k < NUM_REGS; k++)
                                if (shreg_d[ADDR_W-1:0] == ADDR_W'(k)) rd_d = regs_q[k];
                        end
                    end
                end
                WDATA, RDATA: if (cnt_d == CNT_FRAME) state_d = OVER;
                default: ;
            endcase
        end else if (sclk_fall && state_q == RDATA) begin
            miso_d = rd_q[DATA_W-1];
            rd_d   = {rd_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge m_clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            vld_pipe_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            rd_q        <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            regs_q      <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            vld_pipe_q  <= vld_pipe_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;
    assign regs_o      = regs_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: write/read frames, bad lengths, bad addresses,
// mid-frame reset and a cs_n release colliding with the last sclk edge.
module tb_spi_regfile_peripheral;
    localparam int ADDR_W = 7, DATA_W = 8, NUM_REGS = 5, SYNC_STAGES = 2;
    localparam int RW = NUM_REGS * DATA_W;

    logic m_clk = 1'b0;
    logic rst   = 1'b1;
    logic [RW-1:0]     regs_o;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    int total = 0, bad = 0, strobes = 0;
    int s0;
    logic [31:0] cap;

    spi_regfile_peripheral_if spi_if();

    spi_regfile_peripheral #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
                             .SYNC_STAGES(SYNC_STAGES)) dut (
        .m_clk(m_clk), .rst(rst), .spi(spi_if), .regs_o(regs_o),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr));

    always #5 m_clk = ~m_clk;

    // Counts every m_clk cycle with wr_strobe high; one commit must add exactly one.
    always @(posedge m_clk) if (wr_strobe === 1'b1) strobes <= strobes + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge m_clk);
    endtask

    task automatic cs_low();
        spi_if.cs_n = 1'b0;
        clks(4);
    endtask

    task automatic cs_high();
        clks(4);
        spi_if.cs_n = 1'b1;
        clks(8);
    endtask

    // One sclk period of 8 m_clk; MISO is sampled just before the rising edge.
    task automatic bit_out(input logic b, inout logic [31:0] c);
        spi_if.mosi = b;
        clks(4);
        c = {c[30:0], spi_if.miso};
        spi_if.sclk = 1'b1;
        clks(4);
        spi_if.sclk = 1'b0;
    endtask

    task automatic frame(input logic [31:0] bits, input int n, output logic [31:0] c);
        c = '0;
        cs_low();
        for (int i = n - 1; i >= 0; i--) bit_out(bits[i], c);
        cs_high();
    endtask

    initial begin
        logic [31:0] fb;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        spi_if.cs_n = 1'b1;
        cap = '0;
        clks(3);
        chk("rst_regs", regs_o, '0);
        chk("rst_miso", spi_if.miso, 1'b0);
        chk("rst_oe", spi_if.miso_oe, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_addr", wr_addr, '0);
        rst = 1'b0;
        clks(5);

        // Write 0xA5 to reg2, checking cs_n-rise-to-update latency cycle by cycle.
        s0 = strobes;
        fb = 32'h82A5;
        cs_low();
        for (int i = 15; i >= 0; i--) bit_out(fb[i], cap);
        clks(4);
        chk("wr_oe_active", spi_if.miso_oe, 1'b1);
        spi_if.cs_n = 1'b1;
        @(posedge m_clk); @(posedge m_clk); #1;
        chk("wr_not_yet", regs_o, '0);
        @(posedge m_clk); #1;
        chk("wr_reg2", regs_o, 40'h00_00_A5_00_00);
        chk("wr_strobe_hi", wr_strobe, 1'b1);
        chk("wr_addr2", wr_addr, 7'd2);
        @(posedge m_clk); #1;
        chk("wr_strobe_lo", wr_strobe, 1'b0);
        clks(8);
        chk("wr_strobe_cnt", strobes - s0, 1);
        chk("wr_oe_off", spi_if.miso_oe, 1'b0);

        // Read reg2 back on MISO.
        s0 = strobes;
        frame(32'h0200, 16, cap);
        chk("rd_reg2_data", cap[7:0], 8'hA5);
        chk("rd_regs_same", regs_o, 40'h00_00_A5_00_00);
        chk("rd_no_strobe", strobes - s0, 0);
        chk("rd_oe_off", spi_if.miso_oe, 1'b0);
        chk("rd_miso_off", spi_if.miso, 1'b0);

        // Out-of-range address: write ignored, read returns zero.
        s0 = strobes;
        frame(32'h90FF, 16, cap);
        chk("oor_wr_regs", regs_o, 40'h00_00_A5_00_00);
        chk("oor_wr_strobe", strobes - s0, 0);
        cap = '1;
        frame(32'h1000, 16, cap);
        chk("oor_rd_data", cap[7:0], 8'h00);

        // Short and long frames to reg0, then a valid one.
        s0 = strobes;
        frame(32'h401E, 15, cap);
        chk("short_regs", regs_o, 40'h00_00_A5_00_00);
        frame(32'h10078, 17, cap);
        chk("long_regs", regs_o, 40'h00_00_A5_00_00);
        chk("bad_len_strobe", strobes - s0, 0);
        frame(32'h803C, 16, cap);
        chk("good_reg0", regs_o, 40'h00_00_A5_00_3C);
        chk("good_reg0_strobe", strobes - s0, 1);
        chk("good_reg0_addr", wr_addr, 7'd0);

        // Reset after 10 bits of a write to reg1, then finish the frame.
        fb = 32'h8155;
        cs_low();
        for (int i = 15; i >= 6; i--) bit_out(fb[i], cap);
        rst = 1'b1;
        clks(3);
        chk("mid_rst_regs", regs_o, '0);
        chk("mid_rst_oe", spi_if.miso_oe, 1'b0);
        chk("mid_rst_miso", spi_if.miso, 1'b0);
        chk("mid_rst_strobe", wr_strobe, 1'b0);
        chk("mid_rst_addr", wr_addr, '0);
        rst = 1'b0;
        s0 = strobes;
        for (int i = 5; i >= 0; i--) bit_out(fb[i], cap);
        cs_high();
        chk("post_rst_regs", regs_o, '0);
        chk("post_rst_strobe", strobes - s0, 0);
        frame(32'h8155, 16, cap);
        chk("post_rst_commit", regs_o, 40'h00_00_00_55_00);
        chk("post_rst_addr", wr_addr, 7'd1);
        chk("post_rst_strb1", strobes - s0, 1);

        // cs_n release lands in the same cycle as the 16th sclk rise.
        s0 = strobes;
        fb = 32'h8277;
        cs_low();
        for (int i = 15; i >= 1; i--) bit_out(fb[i], cap);
        spi_if.mosi = fb[0];
        clks(4);
        spi_if.sclk = 1'b1;
        spi_if.cs_n = 1'b1;
        clks(4);
        spi_if.sclk = 1'b0;
        clks(8);
        chk("race_regs", regs_o, 40'h00_00_00_55_00);
        chk("race_strobe", strobes - s0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
